fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
//==============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory read bus between the fetch unit and memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Request/wait/execute instruction fetcher with branch redirect
//               and stall. Optional FETCH_ALIGN_CHECK_EN adds misaligned
//               redirect detection (misalign output, HALT on fault).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    fetch_unit_if.master     imem,
    input  wire logic        pcsrc,
    input  wire logic [31:0] pctarget,
    input  wire logic        stall,
    output logic      [31:0] instr,
    output logic      [6:0]  op,
    output logic      [2:0]  funct3,
    output logic             funct7b5,
    output logic             instr_valid,
    output logic      [31:0] pc,
    output logic      [31:0] pcplus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_fetch;
    logic [31:0] pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        req_fetch = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            FETCH: begin
                req_fetch = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                    pc_d    = pc_plus4;
                    if (pcsrc) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        pc_d = pctarget;
                        if (pctarget[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                            state_d    = HALT;
                        end
`else
                        pc_d = pctarget & 32'hFFFF_FFFC;
`endif
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // The state register sits in FETCH while reset is held; the request must not leak out then.
    assign imem.imem_req  = req_fetch & reset_n;
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pcplus4     = pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard testbench for fetch_unit (optionally built with
//               FETCH_ALIGN_CHECK_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        stall;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (bus),
        .pcsrc       (pcsrc),
        .pctarget    (pctarget),
        .stall       (stall),
        .instr       (instr),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        chk("imem_addr", bus.imem_addr, exp_addr);
    endtask

    // Request at addr, ack after 'delay' extra WAIT cycles, then verify EXEC contents.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
        wait_req(addr);
        tick();
        repeat (delay) begin
            chk("req_low_wait", 32'(bus.imem_req), 32'd0);
            chk("valid_low_wait", 32'(instr_valid), 32'd0);
            tick();
        end
        chk("req_low_wait", 32'(bus.imem_req), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        sb.push_back(data);
        tick();
        bus.imem_ack = 1'b0;
        chk("valid_exec", 32'(instr_valid), 32'd1);
        if (sb.size() > 0) chk("instr", instr, sb.pop_front());
        chk("pc", pc, addr);
        chk("pcplus4", pcplus4, addr + 32'd4);
    endtask

    task automatic exec(input logic src, input logic [31:0] tgt);
        pcsrc    = src;
        pctarget = tgt;
        stall    = 1'b0;
        tick();
        pcsrc = 1'b0;
        chk("valid_cleared", 32'(instr_valid), 32'd0);
        chk("instr_nop", instr, NOP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        pcsrc          = 1'b0;
        stall          = 1'b0;
        pctarget       = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (3) tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", 32'(misalign), 32'd0);
`endif
        reset_n = 1'b1;
        #1;
        chk("first_req", 32'(bus.imem_req), 32'd1);

        // Sequential fetch with 3-cycle period
        fetch(32'h0, 32'h0000_0093, 0);
        exec(1'b0, 32'h0);
        chk("period3_req", 32'(bus.imem_req), 32'd1);
        fetch(32'h4, 32'h0010_0113, 0);
        exec(1'b0, 32'h0);
        chk("period3_req", 32'(bus.imem_req), 32'd1);

        // Taken branch
        fetch(32'h8, 32'h0000_0463, 0);
        chk("op_branch", 32'(op), 32'h63);
        chk("funct3_branch", 32'(funct3), 32'd0);
        chk("f7b5_branch", 32'(funct7b5), 32'd0);
        exec(1'b1, 32'h10);

        // Stall hold with pcsrc toggling
        fetch(32'h10, 32'h4000_5033, 0);
        chk("op_r", 32'(op), 32'h33);
        chk("funct3_r", 32'(funct3), 32'd5);
        chk("f7b5_r", 32'(funct7b5), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pcsrc    = i[0];
            pctarget = 32'h100;
            tick();
            chk("stall_pc", pc, 32'h10);
            chk("stall_instr", instr, 32'h4000_5033);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        exec(1'b0, 32'h100);

        // Slow memory with a spurious ack during EXEC
        fetch(32'h14, 32'h0020_8233, 5);
        stall          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("spurious_instr", instr, 32'h0020_8233);
        chk("spurious_req", 32'(bus.imem_req), 32'd0);
        exec(1'b0, 32'h0);
        fetch(32'h18, 32'h00c0_0093, 0);

        // Wrap from top of address space
        exec(1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_006f, 0);
        exec(1'b0, 32'h0);
        fetch(32'h0, 32'h0000_0513, 0);

        // Misaligned redirect
        exec(1'b1, 32'h0000_0006);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_set", 32'(misalign), 32'd1);
        chk("halt_pc", pc, 32'h6);
        repeat (8) begin
            tick();
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end
`else
        wait_req(32'h4);
`endif

        reset_n = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_clr", 32'(misalign), 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        #1;

        // Reset in the middle of WAIT, stale ack right after release
        wait_req(32'h0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midwait_req", 32'(bus.imem_req), 32'd0);
        chk("midwait_pc", pc, 32'h0);
        chk("midwait_instr", instr, NOP);
        chk("midwait_valid", 32'(instr_valid), 32'd0);
        tick();
        reset_n        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBADC_0DE0;
        tick();
        bus.imem_ack = 1'b0;
        chk("stale_valid", 32'(instr_valid), 32'd0);
        chk("stale_instr", instr, NOP);
        chk("stale_addr", bus.imem_addr, 32'h0);
        chk("stale_req", 32'(bus.imem_req), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00a0_0093;
        sb.push_back(32'h00a0_0093);
        tick();
        bus.imem_ack = 1'b0;
        chk("post_rst_valid", 32'(instr_valid), 32'd1);
        if (sb.size() > 0) chk("post_rst_instr", instr, sb.pop_front());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
